// File: rtl/mmio_pkg.sv
// Shared constants and helpers for the cpu-side MMIO bridge.
package mmio_pkg;

   // Address decode: bits [17:16] select the I/O window.
   localparam logic [1:0]  IO_SEL    = 2'b11;
   localparam logic [17:0] ADDR_UART = 18'h30000;
   localparam logic [17:0] ADDR_CLK  = 18'h30004;

   localparam int unsigned RAM_AW_DEFAULT = 17;
   localparam int unsigned BYTE_W         = 8;

   typedef logic [BYTE_W-1:0] byte_t;

   // Source of the data returned one cycle after a read.
   typedef enum logic {
      SelRam = 1'b0,
      SelIo  = 1'b1
   } sel_e;

   // Byte 0 comes from the live counter; bytes 1..3 come from the snapshot
   // taken by the byte-0 read, so a 4-byte load sees one coherent value.
   function automatic byte_t clk_byte(input byte_t      live_lo,
                                      input logic [23:0] snap,
                                      input logic [1:0]  idx);
      byte_t b;
      b = live_lo;
      case (idx)
         2'd1:    b = snap[7:0];
         2'd2:    b = snap[15:8];
         2'd3:    b = snap[23:16];
         default: b = live_lo;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/io_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered occupancy count.
module io_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 8
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       data_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       data_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign count_o = count_q;

   // A push into a full FIFO is accepted only when the head leaves this cycle.
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   // Head is forced to zero while empty so stale entries never show.
   assign data_o = empty_o ? '0 : mem_q[rd_ptr_q];

   // Pointer and count next-state; power-of-2 depth makes pointers wrap naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Storage array; contents need no reset because the count gates visibility.
   always_ff @(posedge clk_in) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

   // Pointer and count registers.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/mmio_bridge.sv
// Splits cpu memory accesses between external RAM and the I/O window
// (UART streams, cycle counter, program-stop flag) and owns the
// one-cycle read-return timing.
module mmio_bridge
   import mmio_pkg::*;
#(
   parameter int unsigned TX_DEPTH = 8,
   parameter int unsigned RAM_AW   = RAM_AW_DEFAULT
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic [31:0]       cpu_a,
   input  logic [7:0]        cpu_wdata,
   input  logic              cpu_wr,
   output logic [7:0]        cpu_rdata,
   output logic [RAM_AW-1:0] ram_a,
   output logic [7:0]        ram_wdata,
   output logic              ram_we,
   input  logic [7:0]        ram_rdata,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_pop,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              tx_ovf,
   output logic              prog_stop
);

   logic [17:0] a18;
   logic        io, is_uart, is_clk, is_clk0;
   logic        rd_en, wr_en;
   byte_t       io_val;

   sel_e        sel_q, sel_d;
   logic        rd_q, rd_d;
   byte_t       io_rdata_q, io_rdata_d;
   logic [31:0] cnt_q, cnt_d;
   logic [23:0] snap_q, snap_d;
   logic        tx_ovf_q, tx_ovf_d;
   logic        prog_stop_q, prog_stop_d;

   logic        tx_req, tx_push, tx_pop, tx_full, tx_empty;
   logic [$clog2(TX_DEPTH):0] tx_count_unused;
   logic        unused_a;

   assign unused_a = ^cpu_a[31:18];

   // Address decode.
   assign a18     = cpu_a[17:0];
   assign io      = (a18[17:16] == IO_SEL);
   assign is_uart = (a18 == ADDR_UART);
   assign is_clk  = (a18[17:2] == ADDR_CLK[17:2]);
   assign is_clk0 = (a18 == ADDR_CLK);
   assign rd_en   = rdy_in & ~cpu_wr;
   assign wr_en   = rdy_in & cpu_wr;

   // RAM side is a pass-through; strobes are held low during reset.
   assign ram_a     = cpu_a[RAM_AW-1:0];
   assign ram_wdata = cpu_wdata;
   assign ram_we    = rst_in & wr_en & ~io;
   assign rx_pop    = rst_in & rd_en & is_uart & rx_valid;

   // tx path: zero bytes are ignored, full-without-pop drops and flags.
   assign tx_req   = wr_en & is_uart & (cpu_wdata != 8'h00);
   assign tx_pop   = tx_valid & tx_ready;
   assign tx_push  = tx_req & (~tx_full | tx_pop);
   assign tx_valid = ~tx_empty;

   // Read value of the addressed I/O register.
   always_comb begin
      io_val = '0;
      if (is_uart) begin
         io_val = rx_valid ? rx_data : '0;
      end else if (is_clk) begin
         io_val = clk_byte(cnt_q[7:0], snap_q, a18[1:0]);
      end
   end

   // Next-state for read-mux registers, counter, snapshot and sticky flags.
   always_comb begin
      sel_d       = sel_q;
      rd_d        = rd_q;
      io_rdata_d  = io_rdata_q;
      snap_d      = snap_q;
      cnt_d       = cnt_q + 32'd1;
      tx_ovf_d    = tx_ovf_q | (tx_req & tx_full & ~tx_pop);
      prog_stop_d = prog_stop_q | (wr_en & is_clk0);
      if (rdy_in) begin
         // rd_q marks that the next cycle carries read data; writes return 0.
         rd_d = ~cpu_wr;
         if (!cpu_wr) begin
            sel_d      = io ? SelIo : SelRam;
            io_rdata_d = io ? io_val : '0;
            if (is_clk0) snap_d = cnt_q[31:8];
         end
      end
   end

   // State registers.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         sel_q       <= SelRam;
         rd_q        <= 1'b0;
         io_rdata_q  <= '0;
         cnt_q       <= '0;
         snap_q      <= '0;
         tx_ovf_q    <= 1'b0;
         prog_stop_q <= 1'b0;
      end else begin
         sel_q       <= sel_d;
         rd_q        <= rd_d;
         io_rdata_q  <= io_rdata_d;
         cnt_q       <= cnt_d;
         snap_q      <= snap_d;
         tx_ovf_q    <= tx_ovf_d;
         prog_stop_q <= prog_stop_d;
      end
   end

   // Read data for the access issued one cycle earlier.
   always_comb begin
      cpu_rdata = '0;
      if (rd_q) cpu_rdata = (sel_q == SelIo) ? io_rdata_q : ram_rdata;
   end

   assign tx_ovf    = tx_ovf_q;
   assign prog_stop = prog_stop_q;

   io_fifo #(
      .DEPTH (TX_DEPTH),
      .WIDTH (BYTE_W)
   ) u_tx_fifo (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .push_i  (tx_push),
      .data_i  (cpu_wdata),
      .pop_i   (tx_pop),
      .data_o  (tx_data),
      .full_o  (tx_full),
      .empty_o (tx_empty),
      .count_o (tx_count_unused)
   );

endmodule

// File: tb/tb_mmio_bridge.sv
// Self-checking bench for mmio_bridge: read-return scoreboard and tx-byte scoreboard.
module tb_mmio_bridge;

   localparam int DEPTH = 8;
   localparam int AW    = 17;

   logic          clk_in = 1'b0;
   logic          rst_in;
   logic          rdy_in;
   logic [31:0]   cpu_a;
   logic [7:0]    cpu_wdata;
   logic          cpu_wr;
   logic [7:0]    cpu_rdata;
   logic [AW-1:0] ram_a;
   logic [7:0]    ram_wdata;
   logic          ram_we;
   logic [7:0]    ram_rdata;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          rx_pop;
   logic [7:0]    tx_data;
   logic          tx_valid;
   logic          tx_ready;
   logic          tx_ovf;
   logic          prog_stop;

   int errors = 0;
   int checks = 0;

   logic [7:0] rd_exp_q [$];
   logic [7:0] tx_exp_q [$];
   logic       obs_rx_pop;
   logic       obs_ram_we;
   logic [7:0] ram_mem [256];
   logic       unused_ram_a;

   assign unused_ram_a = ^ram_a[AW-1:8];

   always #5 clk_in = ~clk_in;

   // Behavioural RAM with one-cycle read latency.
   always @(posedge clk_in) begin
      if (ram_we) ram_mem[ram_a[7:0]] <= ram_wdata;
      ram_rdata <= ram_mem[ram_a[7:0]];
   end

   mmio_bridge #(
      .TX_DEPTH (DEPTH),
      .RAM_AW   (AW)
   ) dut (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .rdy_in    (rdy_in),
      .cpu_a     (cpu_a),
      .cpu_wdata (cpu_wdata),
      .cpu_wr    (cpu_wr),
      .cpu_rdata (cpu_rdata),
      .ram_a     (ram_a),
      .ram_wdata (ram_wdata),
      .ram_we    (ram_we),
      .ram_rdata (ram_rdata),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_pop    (rx_pop),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .tx_ovf    (tx_ovf),
      .prog_stop (prog_stop)
   );

   // One bus cycle, entered and left at a negedge; read expectations go through the queue.
   task automatic step(input logic [31:0] a, input logic wr, input logic [7:0] d,
                       input logic rdy, input logic chk, input logic [7:0] exp_rd,
                       input string name);
      logic [7:0] e;
      cpu_a     = a;
      cpu_wr    = wr;
      cpu_wdata = d;
      rdy_in    = rdy;
      if (chk) rd_exp_q.push_back(exp_rd);
      #1;
      obs_rx_pop = rx_pop;
      obs_ram_we = ram_we;
      @(posedge clk_in);
      @(negedge clk_in);
      if (chk) begin
         e = rd_exp_q.pop_front();
         checks++;
         if (cpu_rdata !== e) begin
            errors++;
            $display("FAIL %s: cpu_rdata=%02h expected %02h", name, cpu_rdata, e);
         end
      end
   endtask

   // Pop every tx byte with tx_ready high and compare against the tx scoreboard.
   task automatic drain(input string name, output int n);
      int guard;
      n = 0;
      guard = 0;
      cpu_wr = 1'b0;
      cpu_a = 32'h0;
      rdy_in = 1'b1;
      tx_ready = 1'b1;
      while (tx_valid === 1'b1 && guard < 4 * DEPTH) begin
         checks++;
         if (tx_exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected tx byte %02h", name, tx_data);
         end else begin
            logic [7:0] e;
            e = tx_exp_q.pop_front();
            if (tx_data !== e) begin
               errors++;
               $display("FAIL %s: tx_data=%02h expected %02h", name, tx_data, e);
            end
         end
         n++;
         guard++;
         @(posedge clk_in);
         @(negedge clk_in);
      end
      tx_ready = 1'b0;
      checks++;
      if (tx_valid !== 1'b0 || tx_exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_end: tx_valid=%b left=%0d expected 0/0", name, tx_valid,
                  tx_exp_q.size());
      end
   endtask

   task automatic test_reset();
      cpu_a = 32'h10; cpu_wr = 1'b1; rdy_in = 1'b1; #1;
      checks++;
      if ({cpu_rdata, tx_data, rx_pop, ram_we, tx_valid, tx_ovf, prog_stop} !== 21'h0) begin
         errors++;
         $display("FAIL reset_outs: got %06h expected 000000",
                  {cpu_rdata, tx_data, rx_pop, ram_we, tx_valid, tx_ovf, prog_stop});
      end
      cpu_wr = 1'b0;
      @(negedge clk_in);
      rst_in = 1'b1;
      step(32'h0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, "idle");
   endtask

   task automatic test_ram();
      step(32'h0000_0010, 1'b1, 8'h55, 1'b1, 1'b0, 8'h00, "ram_wr");
      checks++;
      if (obs_ram_we !== 1'b1) begin
         errors++; $display("FAIL ram_we_wr: got %b expected 1", obs_ram_we);
      end
      step(32'h0000_0010, 1'b0, 8'h00, 1'b1, 1'b1, 8'h55, "ram_rd");
      checks++;
      if (obs_ram_we !== 1'b0) begin
         errors++; $display("FAIL ram_we_rd: got %b expected 0", obs_ram_we);
      end
      step(32'h0000_0021, 1'b1, 8'hC3, 1'b1, 1'b0, 8'h00, "ram_wr2");
      step(32'h0000_0021, 1'b0, 8'h00, 1'b1, 1'b1, 8'hC3, "ram_rd2");
   endtask

   task automatic test_rx();
      rx_valid = 1'b1; rx_data = 8'h41;
      step(32'h0003_0000, 1'b0, 8'h00, 1'b1, 1'b1, 8'h41, "rx_rd");
      checks++;
      if (obs_rx_pop !== 1'b1) begin
         errors++; $display("FAIL rx_pop_valid: got %b expected 1", obs_rx_pop);
      end
      step(32'h0000_0010, 1'b0, 8'h00, 1'b1, 1'b1, 8'h55, "ram_after_io");
      checks++;
      if (obs_rx_pop !== 1'b0) begin
         errors++; $display("FAIL rx_pop_ram: got %b expected 0", obs_rx_pop);
      end
      rx_data = 8'h99;
      step(32'h0003_0001, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, "io_other");
      checks++;
      if (obs_rx_pop !== 1'b0) begin
         errors++; $display("FAIL rx_pop_other: got %b expected 0", obs_rx_pop);
      end
      rx_valid = 1'b0;
      step(32'h0003_0000, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, "rx_empty");
      checks++;
      if (obs_rx_pop !== 1'b0) begin
         errors++; $display("FAIL rx_pop_empty: got %b expected 0", obs_rx_pop);
      end
   endtask

   task automatic test_tx();
      int n;
      tx_ready = 1'b0;
      checks++;
      if (tx_valid !== 1'b0) begin
         errors++; $display("FAIL tx_idle: tx_valid=%b expected 0", tx_valid);
      end
      step(32'h0003_0000, 1'b1, 8'h48, 1'b1, 1'b0, 8'h00, "tx_w0");
      tx_exp_q.push_back(8'h48);
      checks++;
      if (tx_valid !== 1'b1) begin
         errors++; $display("FAIL tx_valid_rise: tx_valid=%b expected 1", tx_valid);
      end
      step(32'h0003_0000, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, "tx_w1");
      step(32'h0003_0000, 1'b1, 8'h49, 1'b1, 1'b0, 8'h00, "tx_w2");
      tx_exp_q.push_back(8'h49);
      drain("tx_drain", n);
      checks++;
      if (n != 2) begin
         errors++; $display("FAIL tx_count: popped %0d expected 2", n);
      end
   endtask

   task automatic test_ovf();
      int n;
      tx_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         step(32'h0003_0000, 1'b1, 8'(i + 1), 1'b1, 1'b0, 8'h00, "fill");
         tx_exp_q.push_back(8'(i + 1));
      end
      checks++;
      if (tx_ovf !== 1'b0) begin
         errors++; $display("FAIL ovf_at_full: tx_ovf=%b expected 0", tx_ovf);
      end
      // Full with a simultaneous pop: the head leaves, the new byte is kept.
      tx_ready = 1'b1;
      checks++;
      if (tx_data !== tx_exp_q[0]) begin
         errors++; $display("FAIL full_head: tx_data=%02h expected %02h", tx_data, tx_exp_q[0]);
      end
      void'(tx_exp_q.pop_front());
      step(32'h0003_0000, 1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, "full_pop_push");
      tx_exp_q.push_back(8'hA5);
      tx_ready = 1'b0;
      checks++;
      if (tx_ovf !== 1'b0) begin
         errors++; $display("FAIL ovf_pop_push: tx_ovf=%b expected 0", tx_ovf);
      end
      step(32'h0003_0000, 1'b1, 8'hEE, 1'b1, 1'b0, 8'h00, "overflow");
      checks++;
      if (tx_ovf !== 1'b1) begin
         errors++; $display("FAIL ovf_set: tx_ovf=%b expected 1", tx_ovf);
      end
      drain("ovf_drain", n);
      checks++;
      if (n != DEPTH || tx_ovf !== 1'b1) begin
         errors++; $display("FAIL ovf_sticky: popped %0d ovf=%b expected %0d/1", n, tx_ovf, DEPTH);
      end
   endtask

   task automatic test_counter();
      force dut.cnt_q = 32'h1234_FFFE;
      #1 release dut.cnt_q;
      step(32'h0003_0004, 1'b0, 8'h00, 1'b1, 1'b1, 8'hFE, "snap_b0");
      step(32'h0003_0005, 1'b0, 8'h00, 1'b1, 1'b1, 8'hFF, "snap_b1");
      step(32'h0003_0006, 1'b0, 8'h00, 1'b1, 1'b1, 8'h34, "snap_b2");
      step(32'h0003_0007, 1'b0, 8'h00, 1'b1, 1'b1, 8'h12, "snap_b3");
      force dut.cnt_q = 32'hFFFF_FFFE;
      #1 release dut.cnt_q;
      step(32'h0003_0004, 1'b0, 8'h00, 1'b1, 1'b1, 8'hFE, "wrap_b0");
      step(32'h0003_0005, 1'b0, 8'h00, 1'b1, 1'b1, 8'hFF, "wrap_b1");
      step(32'h0003_0006, 1'b0, 8'h00, 1'b1, 1'b1, 8'hFF, "wrap_b2");
      step(32'h0003_0007, 1'b0, 8'h00, 1'b1, 1'b1, 8'hFF, "wrap_b3");
      step(32'h0003_0004, 1'b0, 8'h00, 1'b1, 1'b1, 8'h02, "post_wrap_b0");
      step(32'h0003_0007, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, "post_wrap_b3");
      step(32'h0003_0008, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, "io_unmapped");
   endtask

   task automatic test_stop_rdy();
      step(32'h0003_0004, 1'b1, 8'h01, 1'b0, 1'b0, 8'h00, "stop_nordy");
      step(32'h0003_0000, 1'b1, 8'h77, 1'b0, 1'b0, 8'h00, "tx_nordy");
      checks++;
      if ({prog_stop, tx_valid} !== 2'b00) begin
         errors++; $display("FAIL nordy_io: stop/valid=%b expected 00", {prog_stop, tx_valid});
      end
      step(32'h0000_0010, 1'b1, 8'h11, 1'b0, 1'b0, 8'h00, "ram_nordy");
      checks++;
      if (obs_ram_we !== 1'b0) begin
         errors++; $display("FAIL ram_we_nordy: got %b expected 0", obs_ram_we);
      end
      rx_valid = 1'b1; rx_data = 8'h5A;
      step(32'h0003_0000, 1'b0, 8'h00, 1'b1, 1'b1, 8'h5A, "rx_hold_a");
      step(32'h0003_0000, 1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, "rx_hold_b");
      checks++;
      if (obs_rx_pop !== 1'b0) begin
         errors++; $display("FAIL rx_pop_nordy: got %b expected 0", obs_rx_pop);
      end
      rx_valid = 1'b0;
      step(32'h0003_0004, 1'b1, 8'h01, 1'b1, 1'b0, 8'h00, "stop_wr");
      step(32'h0000_0000, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, "idle");
      step(32'h0000_0000, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, "idle");
      checks++;
      if (prog_stop !== 1'b1) begin
         errors++; $display("FAIL prog_stop_sticky: got %b expected 1", prog_stop);
      end
   endtask

   task automatic test_reset_mid();
      tx_ready = 1'b0;
      step(32'h0003_0000, 1'b1, 8'h31, 1'b1, 1'b0, 8'h00, "mid_w0");
      step(32'h0003_0000, 1'b1, 8'h32, 1'b1, 1'b0, 8'h00, "mid_w1");
      rx_valid = 1'b1; rx_data = 8'h66;
      step(32'h0003_0000, 1'b0, 8'h00, 1'b1, 1'b1, 8'h66, "mid_rd");
      rx_valid = 1'b0;
      cpu_a = 32'h10; cpu_wr = 1'b1; cpu_wdata = 8'h22; rdy_in = 1'b1;
      #1 rst_in = 1'b0;
      #1;
      checks++;
      if ({cpu_rdata, tx_data, rx_pop, ram_we, tx_valid, tx_ovf, prog_stop} !== 21'h0) begin
         errors++;
         $display("FAIL reset_mid_outs: got %06h expected 000000",
                  {cpu_rdata, tx_data, rx_pop, ram_we, tx_valid, tx_ovf, prog_stop});
      end
      cpu_wr = 1'b0;
      @(negedge clk_in);
      rst_in = 1'b1;
      #1;
      checks++;
      if ({cpu_rdata, tx_valid} !== 9'h0) begin
         errors++;
         $display("FAIL reset_release: rdata/valid=%03h expected 000", {cpu_rdata, tx_valid});
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ram_mem[i] = 8'h00;
      rst_in = 1'b0; rdy_in = 1'b0; cpu_a = '0; cpu_wdata = '0; cpu_wr = 1'b0;
      rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b0;
      repeat (2) @(negedge clk_in);
      test_reset();
      test_ram();
      test_rx();
      test_tx();
      test_ovf();
      test_counter();
      test_stop_rdy();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
